// File: rtl/pe_pass_sequencer.sv
// Head-of-pipeline control source: walks tap/group/pixel loops for one pass
// and emits one first/last-tagged control token per accumulation step.
module pe_pass_sequencer #(
  parameter int PIXW = 8,
  parameter int TAPW = 4,
  parameter int GRPW = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_cfg_rdy,
  output logic            o_cfg_ack,
  input  logic [PIXW-1:0] i_cfg_npix,
  input  logic [TAPW-1:0] i_cfg_ntap,
  input  logic [GRPW-1:0] i_cfg_ngrp,
  output logic            o_FD_rdy,
  input  logic            i_FD_ack,
  output logic            o_first,
  output logic            o_last,
  output logic [TAPW-1:0] o_tap,
  output logic [GRPW-1:0] o_grp,
  output logic [PIXW-1:0] o_pix,
  output logic            o_done_rdy,
  input  logic            i_done_ack,
  input  logic            i_flush,
  output logic            o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [PIXW-1:0] npix_q, npix_d, pix_q, pix_d;
  logic [TAPW-1:0] ntap_q, ntap_d, tap_q, tap_d;
  logic [GRPW-1:0] ngrp_q, ngrp_d, grp_q, grp_d;
  logic            fdRdy_q, fdRdy_d;
  logic            doneRdy_q, doneRdy_d;
  logic            first_q, first_d;
  logic            last_q, last_d;

  logic            xfer, tapWrap, grpWrap, finalTok;
  logic [TAPW-1:0] tapNext;
  logic [GRPW-1:0] grpNext;
  logic [PIXW-1:0] pixNext;

  assign xfer     = fdRdy_q & i_FD_ack;
  assign tapWrap  = (tap_q == ntap_q);
  assign grpWrap  = tapWrap && (grp_q == ngrp_q);
  assign finalTok = grpWrap && (pix_q == npix_q);

  // Tap is the innermost loop, then channel group, then pixel.
  assign tapNext = tapWrap ? '0 : tap_q + TAPW'(1);
  assign grpNext = tapWrap ? (grpWrap ? '0 : grp_q + GRPW'(1)) : grp_q;
  assign pixNext = grpWrap ? pix_q + PIXW'(1) : pix_q;

  always_comb begin
    state_d   = state_q;
    npix_d    = npix_q;
    ntap_d    = ntap_q;
    ngrp_d    = ngrp_q;
    pix_d     = pix_q;
    tap_d     = tap_q;
    grp_d     = grp_q;
    fdRdy_d   = fdRdy_q;
    doneRdy_d = doneRdy_q;
    first_d   = first_q;
    last_d    = last_q;

    case (state_q)
      IDLE: begin
        if (i_cfg_rdy) begin
          npix_d  = i_cfg_npix;
          ntap_d  = i_cfg_ntap;
          ngrp_d  = i_cfg_ngrp;
          pix_d   = '0;
          tap_d   = '0;
          grp_d   = '0;
          fdRdy_d = 1'b1;
          first_d = 1'b1;
          last_d  = (i_cfg_ntap == '0) && (i_cfg_ngrp == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (finalTok) begin
            // Counters stay on the final token's indices while in DONE.
            fdRdy_d   = 1'b0;
            doneRdy_d = 1'b1;
            first_d   = 1'b0;
            last_d    = 1'b0;
            state_d   = DONE;
          end else begin
            tap_d   = tapNext;
            grp_d   = grpNext;
            pix_d   = pixNext;
            first_d = (tapNext == '0) && (grpNext == '0);
            last_d  = (tapNext == ntap_q) && (grpNext == ngrp_q);
          end
        end
      end
      DONE: begin
        if (i_done_ack) begin
          doneRdy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a config accepted this cycle.
    if (i_flush) begin
      state_d   = IDLE;
      fdRdy_d   = 1'b0;
      doneRdy_d = 1'b0;
      first_d   = 1'b0;
      last_d    = 1'b0;
      pix_d     = '0;
      tap_d     = '0;
      grp_d     = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      npix_q    <= '0;
      ntap_q    <= '0;
      ngrp_q    <= '0;
      pix_q     <= '0;
      tap_q     <= '0;
      grp_q     <= '0;
      fdRdy_q   <= 1'b0;
      doneRdy_q <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      npix_q    <= npix_d;
      ntap_q    <= ntap_d;
      ngrp_q    <= ngrp_d;
      pix_q     <= pix_d;
      tap_q     <= tap_d;
      grp_q     <= grp_d;
      fdRdy_q   <= fdRdy_d;
      doneRdy_q <= doneRdy_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign o_cfg_ack  = (state_q == IDLE);
  assign o_busy     = (state_q != IDLE);
  assign o_FD_rdy   = fdRdy_q;
  assign o_done_rdy = doneRdy_q;
  assign o_first    = first_q;
  assign o_last     = last_q;
  assign o_tap      = tap_q;
  assign o_grp      = grp_q;
  assign o_pix      = pix_q;

endmodule
